// File: rtl/dlx_pkg.sv
// Shared DLX decode definitions: field widths, opcode constants, pipeline
// register bundles and the immediate-extension rule.
package dlx_pkg;

  localparam int OPC_W  = 6;
  localparam int REG_W  = 5;
  localparam int IMM_W  = 16;
  localparam int DATA_W = 32;

  localparam logic [0:OPC_W-1] OP_ANDI = 6'h0C;
  localparam logic [0:OPC_W-1] OP_ORI  = 6'h0D;
  localparam logic [0:OPC_W-1] OP_XORI = 6'h0E;
  localparam logic [0:OPC_W-1] OP_LHI  = 6'h0F;
  localparam logic [0:OPC_W-1] OP_LB   = 6'h20;
  localparam logic [0:OPC_W-1] OP_LH   = 6'h21;
  localparam logic [0:OPC_W-1] OP_LW   = 6'h23;
  localparam logic [0:OPC_W-1] OP_LBU  = 6'h24;
  localparam logic [0:OPC_W-1] OP_LHU  = 6'h25;

  typedef struct packed {
    logic                valid;
    logic [0:OPC_W-1]    opcode;
    logic [0:OPC_W-1]    func;
    logic [0:REG_W-1]    rs1;
    logic [0:REG_W-1]    rs2;
    logic [0:REG_W-1]    rd;
    logic [0:IMM_W-1]    imm;
    logic [0:DATA_W-1]   pc4;
  } ifid_t;

  typedef struct packed {
    logic                valid;
    logic [0:OPC_W-1]    opcode;
    logic [0:OPC_W-1]    func;
    logic [0:REG_W-1]    rs1;
    logic [0:REG_W-1]    rs2;
    logic [0:REG_W-1]    rd;
    logic [0:DATA_W-1]   rega;
    logic [0:DATA_W-1]   regb;
    logic [0:DATA_W-1]   imm_ext;
    logic [0:DATA_W-1]   pc4;
  } idex_t;

  // Bit 0 is the MSB, so LHI places the immediate in the upper half.
  function automatic logic [0:DATA_W-1] extend_imm(input logic [0:OPC_W-1] opc,
                                                    input logic [0:IMM_W-1] imm);
    case (opc)
      OP_ANDI, OP_ORI, OP_XORI: extend_imm = {{(DATA_W-IMM_W){1'b0}}, imm};
      OP_LHI:                   extend_imm = {imm, {(DATA_W-IMM_W){1'b0}}};
      default:                  extend_imm = {{(DATA_W-IMM_W){imm[0]}}, imm};
    endcase
  endfunction

endpackage

// File: rtl/register_file.sv
// General-purpose register file: two asynchronous read ports, one synchronous
// write port, R0 reads as zero, same-cycle write-through to readers.
module register_file #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [0:AW-1]     waddr_i,
  input  logic [0:DATA_W-1] wdata_i,
  input  logic [0:AW-1]     raddr_a_i,
  output logic [0:DATA_W-1] rdata_a_o,
  input  logic [0:AW-1]     raddr_b_i,
  output logic [0:DATA_W-1] rdata_b_o
);

  logic [0:DATA_W-1] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // A nonzero address equal to the write address implies a legal write, so bypass.
  assign rdata_a_o = (raddr_a_i == '0)                   ? '0      :
                     (we_i && (waddr_i == raddr_a_i))    ? wdata_i :
                                                           regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0)                   ? '0      :
                     (we_i && (waddr_i == raddr_b_i))    ? wdata_i :
                                                           regs_q[raddr_b_i];

endmodule

// File: rtl/decode_stage.sv
// DLX instruction-decode stage: IF/ID latch, GPR read, immediate extension,
// load-use hazard detection and registered ID/EX bundle.
// Optional STALL_COUNTER_EN adds a 32-bit count of hazard-stall cycles.
module decode_stage
  import dlx_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallIn,
  input  logic              Flush,
  input  logic [0:OPC_W-1]  OpCode,
  input  logic [0:OPC_W-1]  Function,
  input  logic [0:REG_W-1]  Rs1,
  input  logic [0:REG_W-1]  Rs2,
  input  logic [0:REG_W-1]  Rd,
  input  logic [0:IMM_W-1]  Immediate,
  input  logic [0:DATA_W-1] PCPlusFour,
  input  logic              WrEn,
  input  logic [0:REG_W-1]  WrAddr,
  input  logic [0:DATA_W-1] WrData,
  input  logic              ExMemRead,
  input  logic [0:REG_W-1]  ExRd,
  output logic              HazardStall,
  output logic [0:DATA_W-1] RegA,
  output logic [0:DATA_W-1] RegB,
  output logic [0:DATA_W-1] ImmExt,
  output logic [0:OPC_W-1]  OpCodeOut,
  output logic [0:OPC_W-1]  FunctionOut,
  output logic [0:REG_W-1]  Rs1Out,
  output logic [0:REG_W-1]  Rs2Out,
  output logic [0:REG_W-1]  RdOut,
  output logic [0:DATA_W-1] PCPlusFourOut,
  output logic              ValidOut
`ifdef STALL_COUNTER_EN
  ,
  output logic [0:DATA_W-1] StallCount
`endif
);

  ifid_t ifid_q, ifid_d;
  idex_t idex_q, idex_d, idex_dec;
  logic [0:DATA_W-1] rdata_a, rdata_b;

  register_file #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_i      (WrEn),
    .waddr_i   (WrAddr),
    .wdata_i   (WrData),
    .raddr_a_i (ifid_q.rs1),
    .rdata_a_o (rdata_a),
    .raddr_b_i (ifid_q.rs2),
    .rdata_b_o (rdata_b)
  );

  // Rs2 is compared even for I-type; the occasional false stall is harmless.
  assign HazardStall = ifid_q.valid & ExMemRead & (ExRd != '0) &
                       ((ExRd == ifid_q.rs1) | (ExRd == ifid_q.rs2)) & ~Flush;

  always_comb begin
    idex_dec         = '0;
    idex_dec.valid   = ifid_q.valid;
    idex_dec.opcode  = ifid_q.opcode;
    idex_dec.func    = ifid_q.func;
    idex_dec.rs1     = ifid_q.rs1;
    idex_dec.rs2     = ifid_q.rs2;
    idex_dec.rd      = ifid_q.rd;
    idex_dec.rega    = rdata_a;
    idex_dec.regb    = rdata_b;
    idex_dec.imm_ext = extend_imm(ifid_q.opcode, ifid_q.imm);
    idex_dec.pc4     = ifid_q.pc4;
  end

  // Flush beats StallIn beats HazardStall; squashed payloads simply hold.
  always_comb begin
    ifid_d = ifid_q;
    idex_d = idex_q;
    if (Flush) begin
      ifid_d.valid = 1'b0;
      idex_d.valid = 1'b0;
    end else if (!StallIn) begin
      if (HazardStall) begin
        idex_d = '0;
      end else begin
        idex_d        = idex_dec;
        ifid_d.valid  = 1'b1;
        ifid_d.opcode = OpCode;
        ifid_d.func   = Function;
        ifid_d.rs1    = Rs1;
        ifid_d.rs2    = Rs2;
        ifid_d.rd     = Rd;
        ifid_d.imm    = Immediate;
        ifid_d.pc4    = PCPlusFour;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_q <= '0;
      idex_q <= '0;
    end else begin
      ifid_q <= ifid_d;
      idex_q <= idex_d;
    end
  end

  assign ValidOut      = idex_q.valid;
  assign OpCodeOut     = idex_q.opcode;
  assign FunctionOut   = idex_q.func;
  assign Rs1Out        = idex_q.rs1;
  assign Rs2Out        = idex_q.rs2;
  assign RdOut         = idex_q.rd;
  assign RegA          = idex_q.rega;
  assign RegB          = idex_q.regb;
  assign ImmExt        = idex_q.imm_ext;
  assign PCPlusFourOut = idex_q.pc4;

`ifdef STALL_COUNTER_EN
  logic [0:DATA_W-1] stall_count_q, stall_count_d;

  // HazardStall already excludes Flush, so only StallIn needs masking.
  assign stall_count_d = (HazardStall && !StallIn) ? stall_count_q + DATA_W'(1)
                                                   : stall_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign StallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic against a transaction-level reference model. Honors STALL_COUNTER_EN.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, StallIn, Flush, WrEn, ExMemRead;
  logic [0:5]  OpCode, Function;
  logic [0:4]  Rs1, Rs2, Rd, WrAddr, ExRd;
  logic [0:15] Immediate;
  logic [0:31] PCPlusFour, WrData;
  logic        HazardStall, ValidOut;
  logic [0:31] RegA, RegB, ImmExt, PCPlusFourOut;
  logic [0:5]  OpCodeOut, FunctionOut;
  logic [0:4]  Rs1Out, Rs2Out, RdOut;
`ifdef STALL_COUNTER_EN
  logic [0:31] StallCount;
`endif

  int checks   = 0;
  int failures = 0;

  decode_stage dut (
    .clk(clk), .reset(reset), .StallIn(StallIn), .Flush(Flush),
    .OpCode(OpCode), .Function(Function), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
    .Immediate(Immediate), .PCPlusFour(PCPlusFour),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .ExMemRead(ExMemRead), .ExRd(ExRd), .HazardStall(HazardStall),
    .RegA(RegA), .RegB(RegB), .ImmExt(ImmExt), .OpCodeOut(OpCodeOut),
    .FunctionOut(FunctionOut), .Rs1Out(Rs1Out), .Rs2Out(Rs2Out), .RdOut(RdOut),
    .PCPlusFourOut(PCPlusFourOut), .ValidOut(ValidOut)
`ifdef STALL_COUNTER_EN
    , .StallCount(StallCount)
`endif
  );

  always #5 clk = ~clk;

  logic [155:0] dut_ex;
  assign dut_ex = {ValidOut, OpCodeOut, FunctionOut, Rs1Out, Rs2Out, RdOut,
                   RegA, RegB, ImmExt, PCPlusFourOut};

  // Reference model: architectural registers, pending IF/ID slot, issued ID/EX slot.
  logic [31:0]  m_regs [32];
  logic         m_if_valid;
  logic [5:0]   m_if_opc, m_if_fn;
  logic [4:0]   m_if_rs1, m_if_rs2, m_if_rd;
  logic [15:0]  m_if_imm;
  logic [31:0]  m_if_pc;
  logic [155:0] m_ex;
  logic [31:0]  m_stall_cnt;

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (WrEn && WrAddr == a) return WrData;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] ref_ext(input logic [5:0] opc, input logic [15:0] imm);
    int v;
    v = int'(imm);
    if (opc == 6'h0F) return 32'(v * 65536);
    if (opc == 6'h0C || opc == 6'h0D || opc == 6'h0E) return 32'(v);
    if (v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  function automatic logic ref_hazard();
    return m_if_valid && ExMemRead && ExRd != 5'd0 &&
           (ExRd == m_if_rs1 || ExRd == m_if_rs2) && !Flush;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_if_valid = 1'b0; m_if_opc = '0; m_if_fn = '0; m_if_rs1 = '0; m_if_rs2 = '0;
    m_if_rd = '0; m_if_imm = '0; m_if_pc = '0; m_ex = '0; m_stall_cnt = '0;
  endtask

  task automatic tick();
    logic hz;
    hz = ref_hazard();
    if (Flush) begin
      m_if_valid = 1'b0;
      m_ex[155]  = 1'b0;
    end else if (!StallIn) begin
      if (hz) begin
        m_ex = '0;
        m_stall_cnt = m_stall_cnt + 32'd1;
      end else begin
        m_ex = {m_if_valid, m_if_opc, m_if_fn, m_if_rs1, m_if_rs2, m_if_rd,
                ref_read(m_if_rs1), ref_read(m_if_rs2), ref_ext(m_if_opc, m_if_imm), m_if_pc};
        m_if_valid = 1'b1; m_if_opc = OpCode; m_if_fn = Function; m_if_rs1 = Rs1;
        m_if_rs2 = Rs2; m_if_rd = Rd; m_if_imm = Immediate; m_if_pc = PCPlusFour;
      end
    end
    if (WrEn && WrAddr != 5'd0) m_regs[WrAddr] = WrData;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    StallIn = 0; Flush = 0; WrEn = 0; WrAddr = 0; WrData = 0; ExMemRead = 0; ExRd = 0;
  endtask

  task automatic set_fetch(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [4:0] rd, input logic [15:0] imm,
                           input logic [31:0] pc);
    OpCode = opc; Function = fn; Rs1 = r1; Rs2 = r2; Rd = rd; Immediate = imm; PCPlusFour = pc;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    set_fetch(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0);
    model_reset();
    #1;
    checks++;
    if (dut_ex !== 156'd0) begin
      failures++; $display("[TB] FAIL reset_idex: got %h expected 0", dut_ex);
    end
    checks++;
    if (HazardStall !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_hazard: got %b expected 0", HazardStall);
    end
`ifdef STALL_COUNTER_EN
    checks++;
    if (StallCount !== 32'd0) begin
      failures++; $display("[TB] FAIL reset_count: got %h expected 0", StallCount);
    end
`endif
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_regfile();
    idle();
    WrEn = 1; WrAddr = 5'd5; WrData = 32'h12345678;
    set_fetch(6'h00, 6'h20, 5'd5, 5'd0, 5'd1, 16'h0, 32'h4);
    tick();
    WrEn = 0;
    tick();
    checks++;
    if (RegA !== 32'h12345678 || RegB !== 32'd0 || ValidOut !== 1'b1) begin
      failures++; $display("[TB] FAIL rf_read: got A=%h B=%h V=%b expected A=12345678 B=0 V=1", RegA, RegB, ValidOut);
    end
    set_fetch(6'h00, 6'h20, 5'd7, 5'd0, 5'd2, 16'h0, 32'h8);
    tick();
    WrEn = 1; WrAddr = 5'd7; WrData = 32'hDEADBEEF;
    set_fetch(6'h00, 6'h20, 5'd0, 5'd0, 5'd3, 16'h0, 32'hC);
    tick();
    checks++;
    if (RegA !== 32'hDEADBEEF) begin
      failures++; $display("[TB] FAIL rf_bypass: got %h expected deadbeef", RegA);
    end
    WrAddr = 5'd0; WrData = 32'hFFFFFFFF;
    tick();
    WrEn = 0;
    tick();
    checks++;
    if (RegA !== 32'd0 || RegB !== 32'd0) begin
      failures++; $display("[TB] FAIL rf_r0: got A=%h B=%h expected 0", RegA, RegB);
    end
    checks++;
    if (dut_ex !== m_ex) begin
      failures++; $display("[TB] FAIL rf_model: got %h expected %h", dut_ex, m_ex);
    end
  endtask

  task automatic test_immediate();
    logic [5:0]  opcs [5] = '{6'h08, 6'h0D, 6'h0F, 6'h0C, 6'h08};
    logic [15:0] imms [5] = '{16'h8001, 16'h8001, 16'h8001, 16'hFFFF, 16'h7FFF};
    logic [31:0] exps [5] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'h0000FFFF, 32'h00007FFF};
    idle();
    for (int i = 0; i < 5; i++) begin
      set_fetch(opcs[i], 6'h0, 5'd1, 5'd2, 5'd3, imms[i], 32'h40 + 32'(i));
      tick();
      tick();
      checks++;
      if (ImmExt !== exps[i] || ImmExt !== ref_ext(opcs[i], imms[i])) begin
        failures++; $display("[TB] FAIL imm_ext[%0d]: got %h expected %h", i, ImmExt, exps[i]);
      end
    end
  endtask

  task automatic test_hazard();
    logic [31:0] cnt0;
    idle();
    set_fetch(6'h08, 6'h0, 5'd1, 5'd3, 5'd4, 16'h0010, 32'h100);
    tick();
    set_fetch(6'h08, 6'h0, 5'd9, 5'd10, 5'd11, 16'h0020, 32'h104);
    ExMemRead = 1; ExRd = 5'd3;
    cnt0 = m_stall_cnt;
    #1;
    checks++;
    if (HazardStall !== 1'b1) begin
      failures++; $display("[TB] FAIL hz_detect: got %b expected 1", HazardStall);
    end
    tick();
    checks++;
    if (ValidOut !== 1'b0 || RdOut !== 5'd0 || OpCodeOut !== 6'd0) begin
      failures++; $display("[TB] FAIL hz_bubble: got V=%b Rd=%h Op=%h expected 0 0 0", ValidOut, RdOut, OpCodeOut);
    end
    ExMemRead = 0;
    #1;
    checks++;
    if (HazardStall !== 1'b0) begin
      failures++; $display("[TB] FAIL hz_clear: got %b expected 0", HazardStall);
    end
    tick();
    checks++;
    if (ValidOut !== 1'b1 || Rs2Out !== 5'd3 || RdOut !== 5'd4 || OpCodeOut !== 6'h08 ||
        ImmExt !== 32'h10 || PCPlusFourOut !== 32'h100) begin
      failures++; $display("[TB] FAIL hz_issue: got V=%b Rs2=%h Rd=%h Op=%h Imm=%h PC=%h expected 1 3 4 08 10 100",
                           ValidOut, Rs2Out, RdOut, OpCodeOut, ImmExt, PCPlusFourOut);
    end
`ifdef STALL_COUNTER_EN
    checks++;
    if (StallCount !== cnt0 + 32'd1) begin
      failures++; $display("[TB] FAIL hz_count: got %0d expected %0d", StallCount, cnt0 + 32'd1);
    end
`endif
    tick();
    checks++;
    if (RdOut !== 5'd11 || ValidOut !== 1'b1) begin
      failures++; $display("[TB] FAIL hz_next: got Rd=%h V=%b expected 0b 1", RdOut, ValidOut);
    end
  endtask

  task automatic test_flush_stall();
    logic [31:0] cnt0, last_wr;
    idle();
    set_fetch(6'h00, 6'h20, 5'd2, 5'd6, 5'd8, 16'h0, 32'h200);
    tick();
    tick();
    ExMemRead = 1; ExRd = 5'd2; Flush = 1;
    cnt0 = m_stall_cnt;
    #1;
    checks++;
    if (HazardStall !== 1'b0) begin
      failures++; $display("[TB] FAIL fl_hazard: got %b expected 0", HazardStall);
    end
    tick();
    checks++;
    if (ValidOut !== 1'b0) begin
      failures++; $display("[TB] FAIL fl_idex: got %b expected 0", ValidOut);
    end
    Flush = 0;
    #1;
    checks++;
    if (HazardStall !== 1'b0) begin
      failures++; $display("[TB] FAIL fl_ifid: got %b expected 0", HazardStall);
    end
    ExMemRead = 0;
    tick();
    checks++;
    if (ValidOut !== 1'b0) begin
      failures++; $display("[TB] FAIL fl_bubble_out: got %b expected 0", ValidOut);
    end
    tick();
    // ID/EX now holds the Rs1=2/Rd=8 instruction; freeze it while writing R2.
    StallIn = 1; ExMemRead = 1; ExRd = 5'd2; WrEn = 1; WrAddr = 5'd2;
    last_wr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      last_wr = $urandom;
      WrData = last_wr;
      set_fetch(6'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), $urandom);
      tick();
      checks++;
      if (dut_ex !== m_ex || RdOut !== 5'd8 || ValidOut !== 1'b1) begin
        failures++; $display("[TB] FAIL st_hold[%0d]: got %h expected %h", i, dut_ex, m_ex);
      end
    end
`ifdef STALL_COUNTER_EN
    checks++;
    if (StallCount !== cnt0) begin
      failures++; $display("[TB] FAIL fl_st_count: got %0d expected %0d", StallCount, cnt0);
    end
`endif
    StallIn = 0; ExMemRead = 0; WrEn = 0;
    tick();
    checks++;
    if (dut_ex !== m_ex || RegA !== last_wr || Rs1Out !== 5'd2) begin
      failures++; $display("[TB] FAIL st_release: got %h expected %h", dut_ex, m_ex);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_fetch(6'($urandom_range(0, 63)), 6'($urandom), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom), 16'($urandom), $urandom);
      WrEn = ($urandom_range(0, 2) != 0); WrAddr = 5'($urandom_range(0, 7)); WrData = $urandom;
      ExMemRead = ($urandom_range(0, 2) == 0); ExRd = 5'($urandom_range(0, 7));
      Flush = ($urandom_range(0, 19) == 0); StallIn = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (HazardStall !== ref_hazard()) begin
        failures++; $display("[TB] FAIL rnd_hazard[%0d]: got %b expected %b", n, HazardStall, ref_hazard());
      end
      tick();
      checks++;
      if (m_ex[155] ? (dut_ex !== m_ex) : (ValidOut !== 1'b0)) begin
        failures++; $display("[TB] FAIL rnd_idex[%0d]: got %h expected %h", n, dut_ex, m_ex);
      end
`ifdef STALL_COUNTER_EN
      checks++;
      if (StallCount !== m_stall_cnt) begin
        failures++; $display("[TB] FAIL rnd_count[%0d]: got %0d expected %0d", n, StallCount, m_stall_cnt);
      end
`endif
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    set_fetch(6'h00, 6'h20, 5'd5, 5'd7, 5'd9, 16'h0, 32'h300);
    WrEn = 1; WrAddr = 5'd5; WrData = 32'hA5A5A5A5;
    tick();
    WrAddr = 5'd7; WrData = 32'h5A5A5A5A;
    tick();
    WrEn = 0;
    tick();
    checks++;
    if (ValidOut !== 1'b1) begin
      failures++; $display("[TB] FAIL ar_pre: got %b expected 1", ValidOut);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_ex !== 156'd0 || HazardStall !== 1'b0) begin
      failures++; $display("[TB] FAIL ar_clear: got %h hz=%b expected 0", dut_ex, HazardStall);
    end
    #3;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_fetch(6'h00, 6'h20, 5'(5 + i), 5'(7 + 3 * i), 5'd1, 16'h0, 32'h400);
      tick();
      tick();
      checks++;
      if (RegA !== 32'd0 || RegB !== 32'd0 || ValidOut !== 1'b1) begin
        failures++; $display("[TB] FAIL ar_regs[%0d]: got A=%h B=%h V=%b expected 0 0 1", i, RegA, RegB, ValidOut);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_regfile();
    test_immediate();
    test_hazard();
    test_flush_stall();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage directly downstream of the fetch stage.
- Latches fetch's decoded fields (OpCode, Function, Rs1/Rs2/Rd, Immediate, PCPlusFour) into an IF/ID register.
- Reads a 32x32 GPR file, extends the immediate, detects load-use hazards, and presents results in a registered ID/EX bundle.
- Drives the load-use stall back to fetch's stall input.

Parameters:
- NUM_REGS, 32, number of GPRs; R0 is hardwired to zero.
- DATA_W, 32, register and immediate-extension width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- StallIn  input  1  global freeze (e.g. memory wait); holds IF/ID and ID/EX
- Flush  input  1  taken branch/jump resolved; squash wrong-path instructions
- OpCode  input  [0:5]  from fetch
- Function  input  [0:5]  from fetch
- Rs1, Rs2, Rd  input  [0:4]  from fetch
- Immediate  input  [0:15]  from fetch
- PCPlusFour  input  [0:31]  from fetch
- WrEn  input  1  writeback enable
- WrAddr  input  [0:4]  writeback register
- WrData  input  [0:31]  writeback data
- ExMemRead  input  1  instruction currently in EX is a load
- ExRd  input  [0:4]  destination register of the EX instruction
- HazardStall  output  1  to fetch stall; combinational
- RegA, RegB  output  [0:31]  ID/EX operand values
- ImmExt  output  [0:31]  ID/EX extended immediate
- OpCodeOut, FunctionOut  output  [0:5]  ID/EX
- Rs1Out, Rs2Out, RdOut  output  [0:4]  ID/EX
- PCPlusFourOut  output  [0:31]  ID/EX
- ValidOut  output  1  ID/EX holds a real instruction
- StallCount  output  [0:31]  only when STALL_COUNTER_EN is defined

Behaviour:
- Reset (reset=0, async):
  - All ID/EX outputs 0, ValidOut=0.
  - IF/ID valid=0; HazardStall=0 (follows from IF/ID valid=0).
  - All GPRs cleared to 0.
- Latency: a fetch field presented at edge N appears on the ID/EX outputs after edge N+1 (2 edges).
- IF/ID capture each edge unless frozen. The valid bit loads 1 after reset release.
- Register file:
  - Write on rising edge when WrEn=1 and WrAddr!=0; writes to R0 are ignored.
  - Reads are asynchronous from the IF/ID Rs1/Rs2.
  - Write-through: if WrEn and WrAddr==read address and WrAddr!=0, the read returns WrData in the same cycle.
  - Reads of R0 always return 0.
- Immediate extension (from the IF/ID opcode):
  - 0x0C ANDI, 0x0D ORI, 0x0E XORI: zero-extend.
  - 0x0F LHI: Immediate in bits [0:15], zeros in [16:31].
  - All other opcodes: sign-extend bit 0.
- HazardStall = IF/ID valid & ExMemRead & ExRd!=0 & (ExRd==IF/ID Rs1 | ExRd==IF/ID Rs2) & !Flush.
  - Rs2 is compared regardless of format; a false stall on I-type is accepted.
- Priority per edge: Flush > StallIn > HazardStall > normal.
  - Flush: IF/ID valid←0 and ID/EX ValidOut←0. Payload don't-care but deterministic: hold.
  - StallIn (no Flush): IF/ID and ID/EX both hold. The register file still accepts writes.
  - HazardStall: IF/ID holds; ID/EX loads a bubble (ValidOut=0, RdOut=0, OpCodeOut=0).
  - Normal: ID/EX←decoded IF/ID contents with ValidOut=IF/ID valid; IF/ID←fetch fields.
- Reset asserted mid-operation immediately clears everything, register file included.
- No buffering beyond one IF/ID and one ID/EX entry.

Optional Feature:
- STALL_COUNTER_EN defined:
  - 32-bit StallCount port, reset 0.
  - Increments on every edge where HazardStall=1 and StallIn=0 and Flush=0.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package dlx_pkg holds:
  - Opcode constants (OP_ANDI, OP_ORI, OP_XORI, OP_LHI, OP_LW family).
  - Field widths (OPC_W=6, REG_W=5, IMM_W=16, DATA_W=32).
  - IF/ID and ID/EX bundle typedefs.
- Sub-module register_file: 2 async read ports, 1 sync write port, R0 zero, write-through bypass, async active-low clear.

Test Plan:
- Reset, then write R5=0x12345678 via WB; decode ADD Rs1=5 Rs2=0 -> two edges later RegA=0x12345678, RegB=0, ValidOut=1.
- Same-cycle WB write R7=0xDEADBEEF while decoding Rs1=7 -> RegA=0xDEADBEEF (bypass). Write to R0 -> R0 still reads 0.
- Immediate 0x8001: ADDI -> ImmExt=0xFFFF8001; ORI -> 0x00008001; LHI -> 0x80010000.
- ExMemRead=1, ExRd=3, IF/ID Rs2=3:
  - HazardStall=1 for one cycle; ID/EX bubble (ValidOut=0); IF/ID unchanged.
  - Next cycle with ExMemRead=0, the instruction issues. StallCount=1 if STALL_COUNTER_EN.
- Flush and hazard asserted together -> HazardStall=0, both valids cleared, StallCount unchanged. StallIn=1 for 3 cycles -> ID/EX outputs constant.
- Assert reset low mid-stream with ValidOut=1 -> outputs 0 immediately, no clock needed. After release, reads of any GPR return 0.
